// File: rtl/game_controller.sv
// game_controller: game-flow FSM with BCD score, lives, level and frame-based timers
module game_controller #(
  parameter int START_LIVES       = 3,
  parameter int INVULN_FRAMES     = 120,
  parameter int WAVE_PAUSE_FRAMES = 90,
  parameter int GAMEOVER_FRAMES   = 180,
  parameter int MAX_LEVEL         = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_req,
  input  logic        hit_monster,
  input  logic        hit_player,
  input  logic        wave_cleared,
  output logic [2:0]  game_state,
  output logic        game_active,
  output logic        player_invuln,
  output logic        wave_restart,
  output logic [15:0] score_bcd,
  output logic [1:0]  lives,
  output logic [3:0]  level
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    HIT        = 3'd2,
    WAVE_CLEAR = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [7:0]  timer, timer_n;
  logic [15:0] score_n;
  logic [1:0]  lives_n;
  logic [3:0]  level_n;
  logic        wave_restart_n;
  logic        expire;

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        c = (s[4*i +: 4] == 4'd9);
        r[4*i +: 4] = c ? 4'd0 : s[4*i +: 4] + 4'd1;
      end
    end
    return (s == 16'h9999) ? s : r;
  endfunction

  assign expire = startOfFrame && (timer == 8'd1);

  // state, timer and all outputs registered; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= 8'd0;
      score_bcd     <= 16'h0000;
      lives         <= 2'd0;
      level         <= 4'd1;
      wave_restart  <= 1'b0;
      game_active   <= 1'b0;
      player_invuln <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      score_bcd     <= score_n;
      lives         <= lives_n;
      level         <= level_n;
      wave_restart  <= wave_restart_n;
      game_active   <= (state_n == PLAY) || (state_n == HIT);
      player_invuln <= (state_n == HIT);
    end
  end

  // next-state, timer reload/countdown and game bookkeeping
  always_comb begin
    state_n        = state;
    timer_n        = (startOfFrame && timer != 8'd0) ? timer - 8'd1 : timer;
    score_n        = (hit_monster && (state == PLAY || state == HIT)) ? bcd_inc(score_bcd) : score_bcd;
    lives_n        = lives;
    level_n        = level;
    wave_restart_n = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_n        = PLAY;
          timer_n        = 8'd0;
          score_n        = 16'h0000;
          lives_n        = 2'(START_LIVES);
          level_n        = 4'd1;
          wave_restart_n = 1'b1;
        end
      end
      PLAY: begin
        if (hit_player) begin
          lives_n = lives - 2'd1;
          state_n = (lives == 2'd1) ? GAME_OVER : HIT;
          timer_n = (lives == 2'd1) ? 8'(GAMEOVER_FRAMES) : 8'(INVULN_FRAMES);
        end else if (wave_cleared) begin
          state_n = WAVE_CLEAR;
          timer_n = 8'(WAVE_PAUSE_FRAMES);
        end
      end
      HIT: begin
        if (expire) begin
          state_n = wave_cleared ? WAVE_CLEAR : PLAY;
          timer_n = wave_cleared ? 8'(WAVE_PAUSE_FRAMES) : 8'd0;
        end
      end
      WAVE_CLEAR: begin
        if (expire) begin
          state_n        = PLAY;
          timer_n        = 8'd0;
          level_n        = (level >= 4'(MAX_LEVEL)) ? level : level + 4'd1;
          wave_restart_n = 1'b1;
        end
      end
      GAME_OVER: begin
        if (expire) begin
          state_n = IDLE;
          timer_n = 8'd0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = 8'd0;
      end
    endcase
  end

  assign game_state = state;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller
module tb_game_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        start_req = 1'b0;
  logic        hit_monster = 1'b0;
  logic        hit_player = 1'b0;
  logic        wave_cleared = 1'b0;
  logic [2:0]  game_state;
  logic        game_active;
  logic        player_invuln;
  logic        wave_restart;
  logic [15:0] score_bcd;
  logic [1:0]  lives;
  logic [3:0]  level;
  int          errors = 0;
  int          checks = 0;

  game_controller dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_req(start_req),
    .hit_monster(hit_monster), .hit_player(hit_player), .wave_cleared(wave_cleared),
    .game_state(game_state), .game_active(game_active), .player_invuln(player_invuln),
    .wave_restart(wave_restart), .score_bcd(score_bcd), .lives(lives), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      cyc(1);
      startOfFrame = 1'b0;
      cyc(1);
    end
  endtask

  task automatic wave(input int lvl_after);
    wave_cleared = 1'b1;
    cyc(1);
    wave_cleared = 1'b0;
    frames(90);
    check("wave_state", 16'(game_state), 16'd1);
    check("wave_level", 16'(level), 16'(lvl_after));
  endtask

  initial begin
    cyc(2);
    check("rst_state", 16'(game_state), 16'd0);
    check("rst_lives", 16'(lives), 16'd0);
    check("rst_level", 16'(level), 16'd1);
    check("rst_score", score_bcd, 16'h0000);
    check("rst_wr", 16'(wave_restart), 16'd0);
    check("rst_active", 16'(game_active), 16'd0);
    reset = 1'b0;
    cyc(8);
    hit_monster = 1'b1;
    hit_player = 1'b1;
    wave_cleared = 1'b1;
    cyc(1);
    hit_monster = 1'b0;
    hit_player = 1'b0;
    wave_cleared = 1'b0;
    check("idle_ignore_state", 16'(game_state), 16'd0);
    check("idle_ignore_score", score_bcd, 16'h0000);
    start_req = 1'b1;
    cyc(1);
    start_req = 1'b0;
    check("start_state", 16'(game_state), 16'd1);
    check("start_lives", 16'(lives), 16'd3);
    check("start_level", 16'(level), 16'd1);
    check("start_score", score_bcd, 16'h0000);
    check("start_wr", 16'(wave_restart), 16'd1);
    check("start_active", 16'(game_active), 16'd1);
    cyc(1);
    check("start_wr_drop", 16'(wave_restart), 16'd0);
    hit_monster = 1'b1;
    cyc(1234);
    hit_monster = 1'b0;
    check("score_1234", score_bcd, 16'h1234);
    hit_monster = 1'b1;
    cyc(8764);
    hit_monster = 1'b0;
    check("score_9998", score_bcd, 16'h9998);
    hit_monster = 1'b1;
    cyc(3);
    hit_monster = 1'b0;
    check("score_sat", score_bcd, 16'h9999);
    hit_player = 1'b1;
    cyc(1);
    hit_player = 1'b0;
    check("hit_lives", 16'(lives), 16'd2);
    check("hit_state", 16'(game_state), 16'd2);
    check("hit_invuln", 16'(player_invuln), 16'd1);
    check("hit_active", 16'(game_active), 16'd1);
    hit_player = 1'b1;
    cyc(1);
    hit_player = 1'b0;
    check("hit2_lives", 16'(lives), 16'd2);
    frames(119);
    check("hit_119", 16'(game_state), 16'd2);
    frames(1);
    check("hit_120", 16'(game_state), 16'd1);
    check("hit_invuln_off", 16'(player_invuln), 16'd0);
    hit_player = 1'b1;
    cyc(1);
    hit_player = 1'b0;
    check("hit3_lives", 16'(lives), 16'd1);
    frames(120);
    check("hit3_back", 16'(game_state), 16'd1);
    hit_player = 1'b1;
    wave_cleared = 1'b1;
    cyc(1);
    hit_player = 1'b0;
    wave_cleared = 1'b0;
    check("go_state", 16'(game_state), 16'd4);
    check("go_lives", 16'(lives), 16'd0);
    check("go_active", 16'(game_active), 16'd0);
    start_req = 1'b1;
    cyc(1);
    start_req = 1'b0;
    check("go_start_ign", 16'(game_state), 16'd4);
    frames(179);
    check("go_179", 16'(game_state), 16'd4);
    frames(1);
    check("go_180", 16'(game_state), 16'd0);
    check("go_score_kept", score_bcd, 16'h9999);
    start_req = 1'b1;
    cyc(1);
    start_req = 1'b0;
    check("restart_score", score_bcd, 16'h0000);
    check("restart_lives", 16'(lives), 16'd3);
    hit_monster = 1'b1;
    cyc(1);
    hit_monster = 1'b0;
    check("score_1", score_bcd, 16'h0001);
    wave_cleared = 1'b1;
    cyc(1);
    check("wc_state", 16'(game_state), 16'd3);
    check("wc_active", 16'(game_active), 16'd0);
    hit_monster = 1'b1;
    cyc(1);
    hit_monster = 1'b0;
    check("wc_hm_ign", score_bcd, 16'h0001);
    frames(89);
    check("wc_89", 16'(game_state), 16'd3);
    check("wc_89_level", 16'(level), 16'd1);
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame = 1'b0;
    wave_cleared = 1'b0;
    check("wc_90_state", 16'(game_state), 16'd1);
    check("wc_90_level", 16'(level), 16'd2);
    check("wc_90_wr", 16'(wave_restart), 16'd1);
    cyc(1);
    check("wc_wr_drop", 16'(wave_restart), 16'd0);
    for (int l = 3; l <= 9; l++) wave(l);
    wave(9);
    wave_cleared = 1'b1;
    cyc(1);
    wave_cleared = 1'b0;
    frames(40);
    check("mid_wc", 16'(game_state), 16'd3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_state", 16'(game_state), 16'd0);
    check("mid_rst_score", score_bcd, 16'h0000);
    check("mid_rst_lives", 16'(lives), 16'd0);
    check("mid_rst_level", 16'(level), 16'd1);
    check("mid_rst_wr", 16'(wave_restart), 16'd0);
    check("mid_rst_active", 16'(game_active), 16'd0);
    check("mid_rst_invuln", 16'(player_invuln), 16'd0);
    frames(60);
    check("mid_rst_stay", 16'(game_state), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
